// File: rtl/gmux_sel_ctrl_pkg.sv
// gmux_sel_ctrl_pkg: shared types and constants for the clock-mux select
// sequencing controller (gmux_sel_ctrl and its round-robin arbiter).
package gmux_sel_ctrl_pkg;

    // Number of requesters competing for the mux select
    localparam int NREQ = 2;

    // Default sequencing timing and counter width
    localparam int GATE_CYC_DEF   = 4;
    localparam int SETTLE_CYC_DEF = 8;
    localparam int CNT_W_DEF      = 8;

    // Switch sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_SWITCH = 3'd2,
        ST_SETTLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // One-hot vector for a requester index
    function automatic logic [NREQ-1:0] idx_onehot(input logic idx);
        logic [NREQ-1:0] vec;
        vec = idx ? 2'b10 : 2'b01;
        return vec;
    endfunction

endpackage

// File: rtl/gmux_sel_ctrl_arb.sv
// gmux_sel_ctrl_arb: 2-way round-robin arbiter with a per-requester mask.
// When both eligible requesters are present the pointer's requester wins.
module gmux_sel_ctrl_arb
    import gmux_sel_ctrl_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] mask,
    input  logic            ptr,
    input  logic            en,
    output logic            gnt_vld,
    output logic            gnt_idx
);

    logic [NREQ-1:0] elig_s;

    assign elig_s = req & ~mask;

    // Pick a winner among eligible requesters, pointer breaks ties
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 1'b0;
        if (en) begin
            case (elig_s)
                2'b01: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b0;
                end
                2'b10: begin
                    gnt_vld = 1'b1;
                    gnt_idx = 1'b1;
                end
                2'b11: begin
                    gnt_vld = 1'b1;
                    gnt_idx = ptr;
                end
                default: begin
                    gnt_vld = 1'b0;
                    gnt_idx = 1'b0;
                end
            endcase
        end else begin
            gnt_vld = 1'b0;
            gnt_idx = 1'b0;
        end
    end

endmodule

// File: rtl/gmux_sel_ctrl.sv
// gmux_sel_ctrl: sequencing controller for a two-input clock mux.
// Every select change runs gate-off -> wait -> change select -> settle ->
// gate-on. Runs on an always-on reference clock.
// Optional feature macro: GMUX_SEL_CTRL_LOCK_EN adds a LOCK input that
// freezes new grants while high in IDLE.
module gmux_sel_ctrl
    import gmux_sel_ctrl_pkg::*;
#(
    parameter int GATE_CYC   = GATE_CYC_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int CNT_W      = CNT_W_DEF
)
(
    input  logic            CLK,
    input  logic            RST_N,
    input  logic [NREQ-1:0] REQ,
    input  logic [NREQ-1:0] TGT,
    output logic [NREQ-1:0] ACK,
    output logic            BUSY,
    output logic            IS0,
    output logic            CEN
`ifdef GMUX_SEL_CTRL_LOCK_EN
    ,
    input  logic            LOCK
`endif
);

    localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t          state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic            is0_r, is0_nxt_s;
    logic            cen_r, cen_nxt_s;
    logic [NREQ-1:0] ack_r, ack_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic            ptr_r, ptr_nxt_s;
    logic [NREQ-1:0] mask_r, mask_nxt_s;
    logic            win_r, win_nxt_s;
    logic            tgt_r, tgt_nxt_s;
    logic            lock_s;
    logic            arb_en_s;
    logic            gnt_vld_s;
    logic            gnt_idx_s;
    logic            gnt_tgt_s;

`ifdef GMUX_SEL_CTRL_LOCK_EN
    assign lock_s = LOCK;
`else
    assign lock_s = 1'b0;
`endif

    // Grants are only considered while idle and not frozen
    assign arb_en_s  = (state_r == ST_IDLE) && !lock_s;
    assign gnt_tgt_s = TGT[gnt_idx_s];

    gmux_sel_ctrl_arb u_arb (
        .req     (REQ),
        .mask    (mask_r),
        .ptr     (ptr_r),
        .en      (arb_en_s),
        .gnt_vld (gnt_vld_s),
        .gnt_idx (gnt_idx_s)
    );

    // Next-state and next-output logic of the switch sequencer
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        is0_nxt_s   = is0_r;
        cen_nxt_s   = cen_r;
        ack_nxt_s   = {NREQ{1'b0}};
        ptr_nxt_s   = ptr_r;
        mask_nxt_s  = {NREQ{1'b0}};
        win_nxt_s   = win_r;
        tgt_nxt_s   = tgt_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_vld_s) begin
                    win_nxt_s = gnt_idx_s;
                    tgt_nxt_s = gnt_tgt_s;
                    if (gnt_tgt_s == is0_r) begin
                        // Already on the requested source: acknowledge only
                        state_nxt_s = ST_DONE;
                        ack_nxt_s   = idx_onehot(gnt_idx_s);
                    end else begin
                        state_nxt_s = ST_GATE;
                        cen_nxt_s   = 1'b0;
                        cnt_nxt_s   = GATE_LD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GATE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_SWITCH;
                    is0_nxt_s   = tgt_r;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_SWITCH: begin
                state_nxt_s = ST_SETTLE;
                cnt_nxt_s   = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_ZERO) begin
                    state_nxt_s = ST_DONE;
                    cen_nxt_s   = 1'b1;
                    ack_nxt_s   = idx_onehot(win_r);
                end else begin
                    cnt_nxt_s = cnt_r - CNT_ONE;
                end
            end
            ST_DONE: begin
                // Hand priority over and block an immediate re-grant
                state_nxt_s = ST_IDLE;
                ptr_nxt_s   = ~win_r;
                mask_nxt_s  = idx_onehot(win_r);
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cen_nxt_s   = 1'b1;
            end
        endcase
        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            is0_r   <= 1'b0;
            cen_r   <= 1'b1;
            ack_r   <= {NREQ{1'b0}};
            busy_r  <= 1'b0;
            ptr_r   <= 1'b0;
            mask_r  <= {NREQ{1'b0}};
            win_r   <= 1'b0;
            tgt_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            is0_r   <= is0_nxt_s;
            cen_r   <= cen_nxt_s;
            ack_r   <= ack_nxt_s;
            busy_r  <= busy_nxt_s;
            ptr_r   <= ptr_nxt_s;
            mask_r  <= mask_nxt_s;
            win_r   <= win_nxt_s;
            tgt_r   <= tgt_nxt_s;
        end
    end

    assign ACK  = ack_r;
    assign BUSY = busy_r;
    assign IS0  = is0_r;
    assign CEN  = cen_r;

endmodule

// File: tb/tb_gmux_sel_ctrl.sv
// tb_gmux_sel_ctrl: directed scoreboard bench for gmux_sel_ctrl.
// Instance a uses default timing, instance b uses GATE_CYC=SETTLE_CYC=1.
// The LOCK scenario runs only when GMUX_SEL_CTRL_LOCK_EN is defined.
module tb_gmux_sel_ctrl;

    typedef struct {
        logic [1:0] ack;
        int         cyc;
        logic       is0;
        logic       cen;
    } exp_t;

    logic       CLK;
    logic       rst_a, rst_b;
    logic [1:0] req_a, tgt_a, req_b, tgt_b;
    logic [1:0] ack_a, ack_b;
    logic       busy_a, busy_b, is0_a, is0_b, cen_a, cen_b;
    logic       lock_a, lock_b;

    int   cyc;
    int   total;
    int   bad;
    exp_t qa[$];
    exp_t qb[$];

    gmux_sel_ctrl u_dut_a (
        .CLK   (CLK),
        .RST_N (rst_a),
        .REQ   (req_a),
        .TGT   (tgt_a),
        .ACK   (ack_a),
        .BUSY  (busy_a),
        .IS0   (is0_a),
        .CEN   (cen_a)
`ifdef GMUX_SEL_CTRL_LOCK_EN
        ,
        .LOCK  (lock_a)
`endif
    );

    gmux_sel_ctrl #(.GATE_CYC(1), .SETTLE_CYC(1), .CNT_W(8)) u_dut_b (
        .CLK   (CLK),
        .RST_N (rst_b),
        .REQ   (req_b),
        .TGT   (tgt_b),
        .ACK   (ack_b),
        .BUSY  (busy_b),
        .IS0   (is0_b),
        .CEN   (cen_b)
`ifdef GMUX_SEL_CTRL_LOCK_EN
        ,
        .LOCK  (lock_b)
`endif
    );

    // Reference clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Cycle index: the interval after the k-th rising edge is cycle k
    initial cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance to 1 time unit after the rising edge that starts cycle c
    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Scoreboard monitor for instance a
    always @(negedge CLK) begin
        exp_t e;
        if (ack_a !== 2'b00) begin
            if (qa.size() == 0) begin
                check("a_unexpected_ack", {30'd0, ack_a}, 32'd0);
            end else begin
                e = qa.pop_front();
                check("a_ack_val", {30'd0, ack_a}, {30'd0, e.ack});
                check("a_ack_cyc", cyc, e.cyc);
                check("a_ack_is0", {31'd0, is0_a}, {31'd0, e.is0});
                check("a_ack_cen", {31'd0, cen_a}, {31'd0, e.cen});
            end
        end
    end

    // Scoreboard monitor for instance b
    always @(negedge CLK) begin
        exp_t e;
        if (ack_b !== 2'b00) begin
            if (qb.size() == 0) begin
                check("b_unexpected_ack", {30'd0, ack_b}, 32'd0);
            end else begin
                e = qb.pop_front();
                check("b_ack_val", {30'd0, ack_b}, {30'd0, e.ack});
                check("b_ack_cyc", cyc, e.cyc);
                check("b_ack_is0", {31'd0, is0_b}, {31'd0, e.is0});
                check("b_ack_cen", {31'd0, cen_b}, {31'd0, e.cen});
            end
        end
    end

    initial begin
        int t;
        total  = 0;
        bad    = 0;
        rst_a  = 1'b0;
        rst_b  = 1'b0;
        req_a  = 2'b00;
        tgt_a  = 2'b00;
        req_b  = 2'b00;
        tgt_b  = 2'b00;
        lock_a = 1'b0;
        lock_b = 1'b0;
        @(posedge CLK);
        #1;
        goto(cyc + 3);

        // Reset values
        check("rst_is0", {31'd0, is0_a}, 32'd0);
        check("rst_cen", {31'd0, cen_a}, 32'd1);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_ack", {30'd0, ack_a}, 32'd0);

        // Full switch IP -> IC by requester 0
        t = cyc;
        rst_a = 1'b1;
        req_a = 2'b01;
        tgt_a = 2'b01;
        qa.push_back('{ack: 2'b01, cyc: t + 14, is0: 1'b1, cen: 1'b1});
        goto(t + 1);
        check("sw_c1_cen", {31'd0, cen_a}, 32'd0);
        check("sw_c1_busy", {31'd0, busy_a}, 32'd1);
        goto(t + 2);
        tgt_a = 2'b00;          // must be ignored after the grant
        goto(t + 4);
        check("sw_c4_is0", {31'd0, is0_a}, 32'd0);
        goto(t + 5);
        check("sw_c5_is0", {31'd0, is0_a}, 32'd1);
        goto(t + 13);
        check("sw_c13_cen", {31'd0, cen_a}, 32'd0);
        goto(t + 15);
        req_a = 2'b00;
        check("sw_c15_busy", {31'd0, busy_a}, 32'd0);

        // No-op request from requester 1 (target already selected)
        goto(t + 16);
        t = cyc;
        req_a = 2'b10;
        tgt_a = 2'b10;
        qa.push_back('{ack: 2'b10, cyc: t + 1, is0: 1'b1, cen: 1'b1});
        goto(t + 2);
        req_a = 2'b00;
        check("noop_is0", {31'd0, is0_a}, 32'd1);
        check("noop_cen", {31'd0, cen_a}, 32'd1);
        check("noop_busy", {31'd0, busy_a}, 32'd0);

        // Both requesters from reset: 0 wins (no-op), then 1 switches
        rst_a = 1'b0;
        goto(cyc + 2);
        check("rr_rst_is0", {31'd0, is0_a}, 32'd0);
        t = cyc;
        rst_a = 1'b1;
        req_a = 2'b11;
        tgt_a = 2'b10;
        qa.push_back('{ack: 2'b01, cyc: t + 1, is0: 1'b0, cen: 1'b1});
        qa.push_back('{ack: 2'b10, cyc: t + 16, is0: 1'b1, cen: 1'b1});
        goto(t + 2);
        req_a = 2'b10;
        goto(t + 3);
        check("rr_c3_cen", {31'd0, cen_a}, 32'd0);
        goto(t + 17);
        req_a = 2'b00;
        goto(t + 18);
        check("rr_end_busy", {31'd0, busy_a}, 32'd0);

        // Reset during SETTLE aborts without an ACK
        rst_a = 1'b0;
        goto(cyc + 2);
        t = cyc;
        rst_a = 1'b1;
        req_a = 2'b01;
        tgt_a = 2'b01;
        goto(t + 7);
        check("abort_settle_is0", {31'd0, is0_a}, 32'd1);
        check("abort_settle_cen", {31'd0, cen_a}, 32'd0);
        rst_a = 1'b0;
        req_a = 2'b00;
        goto(t + 8);
        check("abort_is0", {31'd0, is0_a}, 32'd0);
        check("abort_cen", {31'd0, cen_a}, 32'd1);
        check("abort_busy", {31'd0, busy_a}, 32'd0);
        check("abort_ack", {30'd0, ack_a}, 32'd0);
        rst_a = 1'b1;
        goto(t + 30);

        // Shortest timing on instance b
        t = cyc;
        rst_b = 1'b1;
        req_b = 2'b01;
        tgt_b = 2'b01;
        qb.push_back('{ack: 2'b01, cyc: t + 4, is0: 1'b1, cen: 1'b1});
        for (int i = 1; i <= 3; i++) begin
            goto(t + i);
            check("fast_cen_low", {31'd0, cen_b}, 32'd0);
        end
        goto(t + 5);
        req_b = 2'b00;
        check("fast_busy", {31'd0, busy_b}, 32'd0);

`ifdef GMUX_SEL_CTRL_LOCK_EN
        // LOCK holds off a pending request until released
        goto(cyc + 2);
        t = cyc;
        lock_a = 1'b1;
        req_a  = 2'b01;
        tgt_a  = 2'b01;
        qa.push_back('{ack: 2'b01, cyc: t + 24, is0: 1'b1, cen: 1'b1});
        for (int i = 1; i <= 10; i++) begin
            goto(t + i);
            check("lock_busy", {31'd0, busy_a}, 32'd0);
        end
        lock_a = 1'b0;
        goto(t + 11);
        check("lock_gate_cen", {31'd0, cen_a}, 32'd0);
        check("lock_gate_busy", {31'd0, busy_a}, 32'd1);
        goto(t + 25);
        req_a = 2'b00;
`endif

        // Every expected ACK must have been seen
        goto(cyc + 5);
        check("a_pending_acks", qa.size(), 32'd0);
        check("b_pending_acks", qb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
